// File: rtl/register_file_mp_if.sv
// ----------------------------------------------------------------------------
// register_file_mp_if
// Bundles the read, write, reservation and status signals of register_file_mp.
//   master : the client (issue/writeback logic); drives addresses, write data,
//            reservations and flush, and receives read data, busy flags and the
//            write-collision flag.
//   slave  : the register file itself.
// Packed multi-port fields: port p occupies [p*W +: W] of each vector.
// ----------------------------------------------------------------------------
interface register_file_mp_if #(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 5,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 2
);
    logic [READ_PORTS*ADDR_W-1:0]  rdAddr;
    logic [READ_PORTS*XLEN-1:0]    rdData;
    logic [READ_PORTS-1:0]         rdBusy;
    logic [WRITE_PORTS-1:0]        wrEn;
    logic [WRITE_PORTS*ADDR_W-1:0] wrAddr;
    logic [WRITE_PORTS*XLEN-1:0]   wrData;
    logic                          rsvEn;
    logic [ADDR_W-1:0]             rsvAddr;
    logic                          flush;
    logic                          wrCollision;

    modport master (
        output rdAddr, wrEn, wrAddr, wrData, rsvEn, rsvAddr, flush,
        input  rdData, rdBusy, wrCollision
    );

    modport slave (
        input  rdAddr, wrEn, wrAddr, wrData, rsvEn, rsvAddr, flush,
        output rdData, rdBusy, wrCollision
    );
endinterface

// File: rtl/register_file_mp.sv
// ----------------------------------------------------------------------------
// register_file_mp
// Multi-port integer register file with a per-register busy scoreboard.
//   clk    : clock, all state updates on the rising edge
//   resetN : asynchronous active-low reset (clears registers, busy bits and
//            the collision flag)
//   rf     : register_file_mp_if.slave
//            - READ_PORTS combinational read ports (rdAddr -> rdData/rdBusy)
//            - WRITE_PORTS synchronous write ports (wrEn/wrAddr/wrData)
//            - rsvEn/rsvAddr marks a destination busy, flush clears all busy
//            - wrCollision: two write ports hit the same register last cycle
// Register 0 reads as zero and is never busy; out-of-range addresses read as
// zero/not busy and are never written or reserved.
// ----------------------------------------------------------------------------
module register_file_mp #(
    parameter int XLEN        = 32,
    parameter int REG_NUM     = 32,
    parameter int ADDR_W      = 5,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 2,
    parameter int BYPASS      = 1
) (
    input  logic             clk,
    input  logic             resetN,
    register_file_mp_if.slave rf
);

    // Nonzero and inside the implemented register range.
    function automatic logic addrValid(input logic [ADDR_W-1:0] a);
        return (a != '0) && (32'(a) < 32'(REG_NUM));
    endfunction

    logic [XLEN-1:0]    regs [REG_NUM];
    logic [REG_NUM-1:0] busyReg;
    logic [REG_NUM-1:0] busyNext;
    logic               wrCollisionReg;
    logic               collisionNext;

    logic [ADDR_W-1:0]      wrAddrW [WRITE_PORTS];
    logic [XLEN-1:0]        wrDataW [WRITE_PORTS];
    logic [WRITE_PORTS-1:0] wrValid;

    genvar gi;

    // Unpack write ports and qualify each enable with the address check.
    generate
        for (gi = 0; gi < WRITE_PORTS; gi++) begin : gWrPort
            assign wrAddrW[gi] = rf.wrAddr[gi*ADDR_W +: ADDR_W];
            assign wrDataW[gi] = rf.wrData[gi*XLEN +: XLEN];
            assign wrValid[gi] = rf.wrEn[gi] && addrValid(wrAddrW[gi]);
        end
    endgenerate

    // Any pair of valid writes to the same register is a collision.
    always_comb begin
        collisionNext = 1'b0;
        for (int i = 0; i < WRITE_PORTS; i++) begin
            for (int j = i + 1; j < WRITE_PORTS; j++) begin
                if (wrValid[i] && wrValid[j] && (wrAddrW[i] == wrAddrW[j])) begin
                    collisionNext = 1'b1;
                end
            end
        end
    end

    // Scoreboard: flush beats writes, and a new reservation beats both
    // because the newly issued producer supersedes the one being retired.
    always_comb begin
        busyNext = busyReg;
        if (rf.flush) begin
            busyNext = '0;
        end else begin
            for (int w = 0; w < WRITE_PORTS; w++) begin
                if (wrValid[w]) begin
                    busyNext[wrAddrW[w]] = 1'b0;
                end
            end
        end
        if (rf.rsvEn && addrValid(rf.rsvAddr)) begin
            busyNext[rf.rsvAddr] = 1'b1;
        end
        busyNext[0] = 1'b0;
    end

    // State. Ports are walked in ascending order so the highest-index port's
    // assignment lands last and wins a same-address conflict.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int r = 0; r < REG_NUM; r++) begin
                regs[r] <= '0;
            end
            busyReg        <= '0;
            wrCollisionReg <= 1'b0;
        end else begin
            for (int w = 0; w < WRITE_PORTS; w++) begin
                if (wrValid[w]) begin
                    regs[wrAddrW[w]] <= wrDataW[w];
                end
            end
            busyReg        <= busyNext;
            wrCollisionReg <= collisionNext;
        end
    end

    assign rf.wrCollision = wrCollisionReg;

    // Read ports: array lookup, optionally overridden by a same-cycle write.
    generate
        for (gi = 0; gi < READ_PORTS; gi++) begin : gRdPort
            logic [ADDR_W-1:0] readAddr;
            logic [XLEN-1:0]   readData;
            logic              readBusy;

            assign readAddr = rf.rdAddr[gi*ADDR_W +: ADDR_W];

            always_comb begin
                readData = '0;
                readBusy = 1'b0;
                if (addrValid(readAddr)) begin
                    readData = regs[readAddr];
                    readBusy = busyReg[readAddr];
                end
                if (BYPASS != 0) begin
                    // Ascending scan: the highest matching port is applied last.
                    for (int w = 0; w < WRITE_PORTS; w++) begin
                        if (wrValid[w] && (wrAddrW[w] == readAddr)) begin
                            readData = wrDataW[w];
                            readBusy = 1'b0;
                        end
                    end
                end
            end

            assign rf.rdData[gi*XLEN +: XLEN] = readData;
            assign rf.rdBusy[gi]              = readBusy;
        end
    endgenerate

endmodule

// File: tb/tb_register_file_mp.sv
// ----------------------------------------------------------------------------
// tb_register_file_mp
// Directed checks of register_file_mp. Two instances share identical stimulus:
// dutB has bypass enabled, dutN has it disabled, so bypass-dependent
// behaviour can be compared side by side.
// ----------------------------------------------------------------------------
module tb_register_file_mp;

    logic clk;
    logic resetN;
    int   checks;
    int   errors;

    register_file_mp_if #(.XLEN(32), .ADDR_W(5), .READ_PORTS(2), .WRITE_PORTS(2)) ifB ();
    register_file_mp_if #(.XLEN(32), .ADDR_W(5), .READ_PORTS(2), .WRITE_PORTS(2)) ifN ();

    register_file_mp #(.XLEN(32), .REG_NUM(32), .ADDR_W(5), .READ_PORTS(2),
                       .WRITE_PORTS(2), .BYPASS(1)) dutB (
        .clk    (clk),
        .resetN (resetN),
        .rf     (ifB.slave)
    );

    register_file_mp #(.XLEN(32), .REG_NUM(32), .ADDR_W(5), .READ_PORTS(2),
                       .WRITE_PORTS(2), .BYPASS(0)) dutN (
        .clk    (clk),
        .resetN (resetN),
        .rf     (ifN.slave)
    );

    assign ifN.rdAddr  = ifB.rdAddr;
    assign ifN.wrEn    = ifB.wrEn;
    assign ifN.wrAddr  = ifB.wrAddr;
    assign ifN.wrData  = ifB.wrData;
    assign ifN.rsvEn   = ifB.rsvEn;
    assign ifN.rsvAddr = ifB.rsvAddr;
    assign ifN.flush   = ifB.flush;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setRd(input int p, input logic [4:0] a);
        ifB.rdAddr[p*5 +: 5] = a;
    endtask

    task automatic setWr(input int p, input logic en, input logic [4:0] a, input logic [31:0] d);
        ifB.wrEn[p]          = en;
        ifB.wrAddr[p*5 +: 5] = a;
        ifB.wrData[p*32 +: 32] = d;
    endtask

    function automatic logic [31:0] dB(input int p);
        return ifB.rdData[p*32 +: 32];
    endfunction

    function automatic logic [31:0] dN(input int p);
        return ifN.rdData[p*32 +: 32];
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        resetN      = 1'b0;
        ifB.rdAddr  = '0;
        ifB.wrEn    = '0;
        ifB.wrAddr  = '0;
        ifB.wrData  = '0;
        ifB.rsvEn   = 1'b0;
        ifB.rsvAddr = '0;
        ifB.flush   = 1'b0;

        // Reset
        step();
        step();
        #2 resetN = 1'b1;
        step();
        chk("rst_collision", {31'd0, ifB.wrCollision}, 32'd0);
        for (int a = 0; a < 32; a++) begin
            setRd(0, 5'(a));
            setRd(1, 5'(31 - a));
            #1;
            chk($sformatf("rst_data0_x%0d", a), dB(0), 32'd0);
            chk($sformatf("rst_data1_x%0d", 31 - a), dB(1), 32'd0);
            chk($sformatf("rst_busy_x%0d", a), {30'd0, ifB.rdBusy}, 32'd0);
        end
        $display("reset: all 32 registers checked");

        // Write x5 on port 0, visible next cycle (bypass instance sees it now)
        setWr(0, 1'b1, 5'd5, 32'hDEADBEEF);
        setRd(0, 5'd5);
        #1;
        chk("byp_same_cycle_x5", dB(0), 32'hDEADBEEF);
        chk("nobyp_same_cycle_x5", dN(0), 32'd0);
        step();
        setWr(0, 1'b0, 5'd0, 32'd0);
        #1;
        chk("wr_x5_B", dB(0), 32'hDEADBEEF);
        chk("wr_x5_N", dN(0), 32'hDEADBEEF);
        $display("write x5=deadbeef -> read %h", dB(0));

        // Write to x0 is ignored
        setWr(0, 1'b1, 5'd0, 32'h1234);
        setRd(0, 5'd0);
        #1;
        chk("x0_byp", dB(0), 32'd0);
        step();
        setWr(0, 1'b0, 5'd0, 32'd0);
        #1;
        chk("x0_after", dB(0), 32'd0);
        chk("x0_busy", {31'd0, ifB.rdBusy[0]}, 32'd0);
        $display("write x0=1234 -> read %h", dB(0));

        // Bypass on port 1 with x7 reserved
        ifB.rsvEn = 1'b1;
        ifB.rsvAddr = 5'd7;
        setRd(1, 5'd7);
        step();
        ifB.rsvEn = 1'b0;
        #1;
        chk("x7_busy_B", {31'd0, ifB.rdBusy[1]}, 32'd1);
        setWr(1, 1'b1, 5'd7, 32'hA5A5A5A5);
        #1;
        chk("byp_x7_data", dB(1), 32'hA5A5A5A5);
        chk("byp_x7_busy", {31'd0, ifB.rdBusy[1]}, 32'd0);
        chk("nobyp_x7_data", dN(1), 32'd0);
        chk("nobyp_x7_busy", {31'd0, ifN.rdBusy[1]}, 32'd1);
        step();
        setWr(1, 1'b0, 5'd0, 32'd0);
        #1;
        chk("x7_after_N", dN(1), 32'hA5A5A5A5);
        chk("x7_after_busy_N", {31'd0, ifN.rdBusy[1]}, 32'd0);
        $display("bypass x7: B=%h N(next)=%h", dB(1), dN(1));

        // Collision on x3: port 1 wins, flag for exactly one cycle
        setWr(0, 1'b1, 5'd3, 32'h11);
        setWr(1, 1'b1, 5'd3, 32'h22);
        setRd(0, 5'd3);
        #1;
        chk("coll_byp_prio", dB(0), 32'h22);
        chk("coll_flag_pre", {31'd0, ifB.wrCollision}, 32'd0);
        step();
        setWr(0, 1'b0, 5'd0, 32'd0);
        setWr(1, 1'b0, 5'd0, 32'd0);
        #1;
        chk("coll_x3_N", dN(0), 32'h22);
        chk("coll_flag_B", {31'd0, ifB.wrCollision}, 32'd1);
        chk("coll_flag_N", {31'd0, ifN.wrCollision}, 32'd1);
        step();
        chk("coll_flag_clear", {31'd0, ifB.wrCollision}, 32'd0);
        $display("collision x3 -> %h", dN(0));

        // Both ports to x0, then different addresses: no collision
        setWr(0, 1'b1, 5'd0, 32'h1);
        setWr(1, 1'b1, 5'd0, 32'h2);
        step();
        chk("coll_x0", {31'd0, ifB.wrCollision}, 32'd0);
        setWr(0, 1'b1, 5'd20, 32'h20);
        setWr(1, 1'b1, 5'd21, 32'h21);
        step();
        setWr(0, 1'b0, 5'd0, 32'd0);
        setWr(1, 1'b0, 5'd0, 32'd0);
        setRd(0, 5'd20);
        setRd(1, 5'd21);
        #1;
        chk("coll_diff", {31'd0, ifB.wrCollision}, 32'd0);
        chk("x20", dN(0), 32'h20);
        chk("x21", dN(1), 32'h21);
        $display("no-collision writes x20=%h x21=%h", dN(0), dN(1));

        // Scoreboard: reserve x9, then write clears
        ifB.rsvEn = 1'b1;
        ifB.rsvAddr = 5'd9;
        setRd(0, 5'd9);
        #1;
        chk("rsv_x9_pre", {31'd0, ifN.rdBusy[0]}, 32'd0);
        step();
        ifB.rsvEn = 1'b0;
        #1;
        chk("rsv_x9_busy", {31'd0, ifN.rdBusy[0]}, 32'd1);
        setWr(0, 1'b1, 5'd9, 32'h99);
        #1;
        chk("x9_wr_busy_N", {31'd0, ifN.rdBusy[0]}, 32'd1);
        chk("x9_wr_busy_B", {31'd0, ifB.rdBusy[0]}, 32'd0);
        step();
        setWr(0, 1'b0, 5'd0, 32'd0);
        #1;
        chk("x9_clear", {31'd0, ifN.rdBusy[0]}, 32'd0);
        $display("reserve/write x9 -> busy %0d", ifN.rdBusy[0]);

        // Reserve and write x9 together: reservation wins
        ifB.rsvEn = 1'b1;
        ifB.rsvAddr = 5'd9;
        setWr(0, 1'b1, 5'd9, 32'h1999);
        step();
        ifB.rsvEn = 1'b0;
        setWr(0, 1'b0, 5'd0, 32'd0);
        #1;
        chk("x9_rsv_wr_busy", {31'd0, ifN.rdBusy[0]}, 32'd1);
        chk("x9_rsv_wr_data", dN(0), 32'h1999);
        $display("reserve+write x9 -> busy %0d data %h", ifN.rdBusy[0], dN(0));

        // Reserve x10, then flush while reserving x4
        ifB.rsvEn = 1'b1;
        ifB.rsvAddr = 5'd10;
        step();
        setRd(1, 5'd10);
        ifB.flush = 1'b1;
        ifB.rsvAddr = 5'd4;
        #1;
        chk("x10_busy_pre", {31'd0, ifN.rdBusy[1]}, 32'd1);
        step();
        ifB.flush = 1'b0;
        ifB.rsvEn = 1'b0;
        #1;
        chk("flush_x9", {31'd0, ifN.rdBusy[0]}, 32'd0);
        chk("flush_x10", {31'd0, ifN.rdBusy[1]}, 32'd0);
        setRd(1, 5'd4);
        #1;
        chk("flush_x4", {31'd0, ifN.rdBusy[1]}, 32'd1);
        $display("flush+reserve x4 -> x9=%0d x4=%0d", ifN.rdBusy[0], ifN.rdBusy[1]);

        // Reserving x0 has no effect
        ifB.rsvEn = 1'b1;
        ifB.rsvAddr = 5'd0;
        setRd(0, 5'd0);
        step();
        ifB.rsvEn = 1'b0;
        #1;
        chk("rsv_x0", {31'd0, ifN.rdBusy[0]}, 32'd0);

        // Async reset mid-cycle while x4 busy and writes pending
        setRd(0, 5'd5);
        setRd(1, 5'd4);
        setWr(0, 1'b1, 5'd12, 32'h55);
        setWr(1, 1'b1, 5'd12, 32'h66);
        #1;
        chk("pre_rst_x5", dN(0), 32'hDEADBEEF);
        #1 resetN = 1'b0;
        #1;
        chk("async_x5", dN(0), 32'd0);
        chk("async_x4_busy", {31'd0, ifN.rdBusy[1]}, 32'd0);
        step();
        step();
        #2;
        setWr(0, 1'b0, 5'd0, 32'd0);
        setWr(1, 1'b0, 5'd0, 32'd0);
        resetN = 1'b1;
        setRd(0, 5'd12);
        #1;
        chk("async_x12", dN(0), 32'd0);
        chk("async_coll", {31'd0, ifN.wrCollision}, 32'd0);
        step();
        chk("post_rst_x12", dN(0), 32'd0);
        chk("post_rst_coll", {31'd0, ifN.wrCollision}, 32'd0);
        $display("async reset -> x12=%h collision=%0d", dN(0), ifN.wrCollision);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
